// File: rtl/ioram_loader_pkg.sv
// Shared types and constants for the I/O RAM serial loader.
//   ADDR_W         : width of the I/O RAM address and of the byte counter
//   loader_state_t : receive/write sequencing states
package ioram_loader_pkg;

  localparam int unsigned ADDR_W = 14;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWrite
  } loader_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: input synchroniser, bit timer and LSB-first shift register.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   rx          : raw serial line (idles high)
//   start_en    : a new frame may only be detected while this is high
//   busy        : receiver is inside a frame
//   byte_valid  : one-cycle pulse, stop bit sampled high; data holds the byte
//   frame_err   : one-cycle pulse, stop bit sampled low
//   data        : shift register contents
module uart_rx_core
  import ioram_loader_pkg::*;
#(
  parameter int unsigned ClksPerBit = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       start_en,
  output logic       busy,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] data
);

  localparam int unsigned TimerW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [TimerW-1:0] HalfLast = TimerW'(ClksPerBit / 2 - 1);
  localparam logic [TimerW-1:0] BitLast  = TimerW'(ClksPerBit - 1);

  logic              rx_meta_q, rx_s_q;
  loader_state_t     state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              bit_tick, half_tick;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign bit_tick  = (timer_q == BitLast);
  assign half_tick = (timer_q == HalfLast);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_en && !rx_s_q) state_d = StStart;
      // Line back high at mid start bit is treated as a glitch.
      StStart: if (half_tick) state_d = rx_s_q ? StIdle : StData;
      StData:  if (bit_tick && (bit_idx_q == 3'd7)) state_d = StStop;
      StStop:  if (bit_tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (state_q != StIdle);
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if ((state_q == StStop) && bit_tick) begin
      byte_valid = rx_s_q;
      frame_err  = !rx_s_q;
    end
  end

  assign data = shift_q;

  // Bit timer, bit index and shift register
  always_comb begin
    timer_d   = timer_q + TimerW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      StIdle: timer_d = '0;
      StStart: begin
        if (half_tick) begin
          timer_d   = '0;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          timer_d   = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StStop:  if (bit_tick) timer_d = '0;
      default: timer_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: rtl/ioram_uart_loader.sv
// Serial-to-I/O-RAM loader: writes each good 8N1 byte to consecutive I/O RAM
// addresses starting at BASE_ADDR.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   Rx          : serial input (idles high)
//   Enable      : allows new frames to start
//   Clear       : synchronous pointer/count/error clear
//   Address     : current write pointer
//   DataWrite   : last received good byte
//   WrEnable    : one-cycle I/O RAM write strobe
//   Busy        : receiving or writing
//   FrameError  : sticky bad-stop-bit flag
//   ByteCount   : bytes written, saturating at MEM_DEPTH
module ioram_uart_loader
  import ioram_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned MEM_DEPTH = 10240,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Rx,
  input  logic              Enable,
  input  logic              Clear,
  output logic [ADDR_W-1:0] Address,
  output logic [7:0]        DataWrite,
  output logic              WrEnable,
  output logic              Busy,
  output logic              FrameError,
  output logic [ADDR_W-1:0] ByteCount
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] CountMax = ADDR_W'(MEM_DEPTH);

  logic              rx_busy, rx_valid, rx_ferr;
  logic [7:0]        rx_data;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic              ferr_q, ferr_d;

  // No start detection during the write cycle.
  uart_rx_core #(
    .ClksPerBit(ClksPerBit)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (Rx),
    .start_en  (Enable && !write_q),
    .busy      (rx_busy),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr),
    .data      (rx_data)
  );

  always_comb begin
    write_d = rx_valid;
    data_d  = rx_valid ? rx_data : data_q;
    ferr_d  = ferr_q | rx_ferr;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (write_q) begin
      // Wrap goes to 0, not to the base address.
      ptr_d = (ptr_q == LastAddr) ? '0 : ptr_q + ADDR_W'(1);
      if (cnt_q != CountMax) cnt_d = cnt_q + ADDR_W'(1);
    end
    // Clear wins over the post-write increment; the write itself still happens.
    if (Clear) begin
      ptr_d  = BaseAddr;
      cnt_d  = '0;
      ferr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      ptr_q   <= BaseAddr;
      cnt_q   <= '0;
    end else begin
      write_q <= write_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Address    = ptr_q;
  assign DataWrite  = data_q;
  assign WrEnable   = write_q;
  assign Busy       = rx_busy | write_q;
  assign FrameError = ferr_q;
  assign ByteCount  = cnt_q;

endmodule

// File: tb/tb_ioram_uart_loader.sv
// Self-checking bench for ioram_uart_loader. Four instances share the serial
// stimulus, each with a different base/depth, and are compared against a
// per-instance reference model of pointer, count, error flag and write log.
module tb_ioram_uart_loader;

  localparam int N     = 10;  // 50 MHz / 5 MHz
  localparam int NInst = 4;

  function automatic int unsigned base_of(input int g);
    case (g)
      0:       return 0;
      1:       return 100;
      2:       return 10239;
      default: return 6;
    endcase
  endfunction

  function automatic int unsigned depth_of(input int g);
    return (g == 3) ? 8 : 10240;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic [13:0] addr [NInst];
  logic [7:0]  dwr  [NInst];
  logic        we   [NInst];
  logic        busy [NInst];
  logic        ferr [NInst];
  logic [13:0] bcnt [NInst];

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    ioram_uart_loader #(
      .CLK_FREQ (50_000_000),
      .BAUD     (5_000_000),
      .MEM_DEPTH(depth_of(g)),
      .BASE_ADDR(base_of(g))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .Rx        (rx),
      .Enable    (enable),
      .Clear     (clear),
      .Address   (addr[g]),
      .DataWrite (dwr[g]),
      .WrEnable  (we[g]),
      .Busy      (busy[g]),
      .FrameError(ferr[g]),
      .ByteCount (bcnt[g])
    );
  end

  always #10 clk = ~clk;

  // Observed writes as (address << 8) | data.
  int wq [NInst][$];
  always @(negedge clk) begin
    for (int g = 0; g < NInst; g++) begin
      if (we[g] === 1'b1) wq[g].push_back((int'(addr[g]) << 8) | int'(dwr[g]));
    end
  end

  // Reference model
  int unsigned m_ptr  [NInst];
  int unsigned m_cnt  [NInst];
  bit          m_fe   [NInst];
  int unsigned m_data [NInst];
  int          exp_q  [NInst][$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int g, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, g, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NInst; g++) begin
      m_ptr[g]  = base_of(g);
      m_cnt[g]  = 0;
      m_fe[g]   = 1'b0;
      m_data[g] = 0;
      exp_q[g].delete();
      wq[g].delete();
    end
  endtask

  task automatic model_clear();
    for (int g = 0; g < NInst; g++) begin
      m_ptr[g] = base_of(g);
      m_cnt[g] = 0;
      m_fe[g]  = 1'b0;
    end
  endtask

  task automatic model_write(input logic [7:0] b);
    for (int g = 0; g < NInst; g++) begin
      exp_q[g].push_back(int'(m_ptr[g] << 8) | int'(b));
      m_data[g] = b;
      m_ptr[g]  = (m_ptr[g] + 1) % depth_of(g);
      if (m_cnt[g] < depth_of(g)) m_cnt[g]++;
    end
  endtask

  task automatic model_ferr();
    for (int g = 0; g < NInst; g++) m_fe[g] = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input bit exp_busy);
    for (int g = 0; g < NInst; g++) begin
      chk({tag, ".addr"}, g, 32'(addr[g]), m_ptr[g]);
      chk({tag, ".count"}, g, 32'(bcnt[g]), m_cnt[g]);
      chk({tag, ".ferr"}, g, 32'(ferr[g]), 32'(m_fe[g]));
      chk({tag, ".data"}, g, 32'(dwr[g]), m_data[g]);
      chk({tag, ".we"}, g, 32'(we[g]), 0);
      chk({tag, ".busy"}, g, 32'(busy[g]), 32'(exp_busy));
    end
  endtask

  // Let the line settle, then compare the write log and all outputs.
  task automatic settle_and_check(input string tag);
    repeat (2 * N) @(negedge clk);
    for (int g = 0; g < NInst; g++) begin
      chk({tag, ".nwrites"}, g, 32'(wq[g].size()), 32'(exp_q[g].size()));
      for (int i = 0; i < exp_q[g].size(); i++) begin
        if (i < wq[g].size()) chk({tag, ".write"}, g, 32'(wq[g][i]), 32'(exp_q[g][i]));
      end
      wq[g].delete();
      exp_q[g].delete();
    end
    check_outputs(tag, 1'b0);
  endtask

  // Drives one frame; optionally pulses Clear in the cycle WrEnable is high.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit exp_busy,
                            input bit clr_on_write);
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (N / 2) @(negedge clk);
      if (k == 4) chk("midframe.busy", 0, 32'(busy[0]), 32'(exp_busy));
      repeat (N - N / 2) @(negedge clk);
    end
    rx = stop_ok;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      if (clr_on_write && (we[0] === 1'b1)) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] burst [3];
    burst[0] = 8'h00;
    burst[1] = 8'hFF;
    burst[2] = 8'h3C;

    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset", 1'b0);

    // Single byte
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    model_write(8'hA5);
    settle_and_check("a5");

    // Back-to-back frames, no idle gap
    for (int i = 0; i < 3; i++) begin
      send_frame(burst[i], 1'b1, 1'b1, 1'b0);
      model_write(burst[i]);
    end
    settle_and_check("burst");

    // Random bytes with random idle gaps
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b1, 1'b0);
      model_write(b);
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    settle_and_check("random");

    // Stop bit low: discarded, sticky error
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    model_ferr();
    settle_and_check("badstop");
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    model_write(8'h11);
    settle_and_check("after_bad");

    // Short low glitch
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    settle_and_check("glitch");

    // Enable low: nothing starts
    enable = 1'b0;
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    settle_and_check("disabled");
    enable = 1'b1;

    // Idle Clear
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    settle_and_check("clear_idle");

    // A few more bytes so state is non-trivial before reset
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(1, 255));
      send_frame(b, 1'b1, 1'b1, 1'b0);
      model_write(b);
    end
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
    model_ferr();
    settle_and_check("pre_reset");

    // Reset in the middle of the data bits
    rx = 1'b0;
    repeat (N) @(negedge clk);
    rx = 1'b1;
    repeat (N) @(negedge clk);
    rx = 1'b0;
    repeat (N + N / 2) @(negedge clk);
    chk("prereset.busy", 0, 32'(busy[0]), 1);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset", 1'b0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    settle_and_check("post_reset");

    // Clear coinciding with the write strobe
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    model_write(8'h5A);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
    model_write(8'hC3);
    model_clear();
    settle_and_check("clear_on_write");

    // Writing resumes from the base
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b1, 1'b0);
    model_write(b);
    settle_and_check("resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
